// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: function codes and FSM state encodings shared by the sequential ALU core.
package alu_seq_pkg;

    localparam logic [3:0] F_AND = 4'b0000;
    localparam logic [3:0] F_OR  = 4'b0001;
    localparam logic [3:0] F_ADD = 4'b0010;
    localparam logic [3:0] F_SUB = 4'b0110;
    localparam logic [3:0] F_SLT = 4'b0111;
    localparam logic [3:0] F_NOR = 4'b1100;
    localparam logic [3:0] F_MUL = 4'b1000;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative shift-add multiplier, one multiplier bit per step.
// product presents the accumulator including the current step, so it is final when done=1.
module alu_mul_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] acc_next_s;

    // Partial-product accumulate for the current multiplier bit
    always_comb begin
        if (mplier_r[0]) begin
            acc_next_s = acc_r + mcand_r;
        end else begin
            acc_next_s = acc_r;
        end
    end

    assign done    = step && (cnt_r == CNT_W'(1'b1));
    assign product = acc_next_s;

    // Shift-add iteration registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r    <= {WIDTH{1'b0}};
            mcand_r  <= {WIDTH{1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
        end else if (load) begin
            acc_r    <= {WIDTH{1'b0}};
            mcand_r  <= a;
            mplier_r <= b;
            cnt_r    <= CNT_W'(WIDTH);
        end else if (step && (cnt_r != {CNT_W{1'b0}})) begin
            acc_r    <= acc_next_s;
            mcand_r  <= {mcand_r[WIDTH-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
            cnt_r    <= cnt_r - CNT_W'(1'b1);
        end
    end

endmodule

// File: rtl/alu_seq_core.sv
// alu_seq_core: registered WIDTH-bit ALU with valid/ready handshake on both sides.
// Define ALU_SEQ_MUL_EN to build the iterative multiplier for F=1000; otherwise F=1000 is illegal.
module alu_seq_core
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       F,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             ovf,
    output logic             err
);

    logic             accept_s;
    logic             is_mul_s;
    logic             err_s;
    logic             ovf_s;
    logic             lt_s;
    logic [WIDTH-1:0] res_s;
    logic [WIDTH-1:0] sum_s;
    logic [WIDTH-1:0] diff_s;
    logic             mul_done_s;
    logic [WIDTH-1:0] mul_product_s;
    state_t           state_s;

    logic             out_valid_r;
    logic [WIDTH-1:0] y_r;
    logic             zero_r;
    logic             ovf_r;
    logic             err_r;

    assign sum_s  = a + b;
    assign diff_s = a + ~b + {{(WIDTH-1){1'b0}}, 1'b1};
    assign lt_s   = $signed(a) < $signed(b);

    // Single-cycle operation mux; MUL only flags the request for the FSM
    always_comb begin
        res_s    = {WIDTH{1'b0}};
        ovf_s    = 1'b0;
        err_s    = 1'b0;
        is_mul_s = 1'b0;
        case (F)
            F_AND: res_s = a & b;
            F_OR:  res_s = a | b;
            F_ADD: begin
                res_s = sum_s;
                ovf_s = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
            end
            F_SUB: begin
                res_s = diff_s;
                ovf_s = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
            end
            F_SLT: res_s = {{(WIDTH-1){1'b0}}, lt_s};
            F_NOR: res_s = ~(a | b);
`ifdef ALU_SEQ_MUL_EN
            F_MUL: is_mul_s = 1'b1;
`endif
            default: err_s = 1'b1;
        endcase
    end

    assign in_ready = !rst && (state_s == S_IDLE) && (!out_valid_r || out_ready);
    assign accept_s = in_valid && in_ready;

`ifdef ALU_SEQ_MUL_EN
    state_t state_r;
    state_t next_state_s;
    logic   mul_load_s;

    // Next-state logic: IDLE -> BUSY on an accepted MUL, back on the final step
    always_comb begin
        next_state_s = state_r;
        mul_load_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (accept_s && is_mul_s) begin
                    next_state_s = S_BUSY;
                    mul_load_s   = 1'b1;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_BUSY: begin
                if (mul_done_s) begin
                    next_state_s = S_IDLE;
                end else begin
                    next_state_s = S_BUSY;
                end
            end
            default: next_state_s = S_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    assign state_s = state_r;

    alu_mul_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .load    (mul_load_s),
        .step    (state_r == S_BUSY),
        .a       (a),
        .b       (b),
        .done    (mul_done_s),
        .product (mul_product_s)
    );
`else
    assign state_s       = S_IDLE;
    assign mul_done_s    = 1'b0;
    assign mul_product_s = {WIDTH{1'b0}};
`endif

    // Result registers; a new single-cycle accept overwrites a result consumed in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            y_r         <= {WIDTH{1'b0}};
            zero_r      <= 1'b0;
            ovf_r       <= 1'b0;
            err_r       <= 1'b0;
        end else if (mul_done_s) begin
            out_valid_r <= 1'b1;
            y_r         <= mul_product_s;
            zero_r      <= (mul_product_s == {WIDTH{1'b0}});
            ovf_r       <= 1'b0;
            err_r       <= 1'b0;
        end else if (accept_s && !is_mul_s) begin
            out_valid_r <= 1'b1;
            y_r         <= res_s;
            zero_r      <= (res_s == {WIDTH{1'b0}});
            ovf_r       <= ovf_s;
            err_r       <= err_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign out_valid = out_valid_r;
    assign y         = y_r;
    assign zero      = zero_r;
    assign ovf       = ovf_r;
    assign err       = err_r;

endmodule
